program_loader: RTL

Byte-stream instruction-memory loader for the RISC-V core. It receives a length-prefixed program over a valid/ready byte interface and zero-fills the 32-word program memory. It then writes the program into that memory as little-endian 32-bit words and releases the core through `core_start`. It is the writer side of the core's instruction fetch path: the core only reads program memory, and this block fills it.

---
 rtl/program_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - length-prefixed byte-stream loader for the 32-word program memory
module program_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              core_start,
    output logic              err
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              core_start_q, core_start_d;
    logic              err_q, err_d;
    logic              accept;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        widx_d  = widx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        if (load_req) begin
            state_d = S_CLEAR;
            widx_d  = '0;
            bcnt_d  = '0;
            asm_d   = '0;
        end else begin
            case (state_q)
                S_CLEAR: if (mem_addr_q == ADDR_W'(DEPTH - 1)) state_d = S_HDR;
                S_HDR: if (accept) begin
                    if (in_data != 8'd0 && 32'(in_data) <= 32'(DEPTH)) begin
                        n_d     = in_data;
                        widx_d  = '0;
                        bcnt_d  = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_DATA: if (accept) begin
                    case (bcnt_q)
                        2'd0: asm_d[7:0]   = in_data;
                        2'd1: asm_d[15:8]  = in_data;
                        2'd2: asm_d[23:16] = in_data;
                        default: ;
                    endcase
                    if (bcnt_q == 2'd3) begin
                        bcnt_d  = '0;
                        state_d = S_WRITE;
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (32'(widx_q) + 32'd1 == 32'(n_q)) begin
                        state_d = S_DONE;
                    end else begin
                        widx_d  = widx_q + ADDR_W'(1);
                        state_d = S_DATA;
                    end
                end
                default: ;
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        mem_we_d    = (state_d == S_CLEAR) || (state_d == S_WRITE);
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (state_d == S_CLEAR) begin
            mem_addr_d = (state_q == S_CLEAR && !load_req) ? mem_addr_q + ADDR_W'(1) : '0;
        end else if (state_d == S_WRITE) begin
            mem_addr_d  = widx_q;
            mem_wdata_d = {in_data, asm_q};
        end
        in_ready_d   = (state_d == S_HDR) || (state_d == S_DATA);
        busy_d       = (state_d == S_CLEAR) || (state_d == S_HDR) ||
                       (state_d == S_DATA)  || (state_d == S_WRITE);
        core_start_d = (state_d == S_DONE);
        err_d        = (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            widx_q       <= '0;
            bcnt_q       <= '0;
            asm_q        <= '0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            core_start_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            widx_q       <= widx_d;
            bcnt_q       <= bcnt_d;
            asm_q        <= asm_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            core_start_q <= core_start_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign core_start = core_start_q;
    assign err        = err_q;
endmodule
